// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: owns the PC, runs a req/ack read against instruction memory
// and hands each word to the IR as a one-cycle ir_ld pulse. Optional FETCH_TIMEOUT_EN adds an ack timeout.
module instr_fetch #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ir_ld,
    output logic [DATA_W-1:0] ir_data,
    output logic [ADDR_W-1:0] pc_out,
    output logic              busy,
    output logic              fetch_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_LOAD  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic [DATA_W-1:0] ir_data_q, ir_data_d;
    logic              ir_ld_q, ir_ld_d;
    logic              redirect_q, redirect_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;

`ifdef FETCH_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_out_d   = pc_out_q;
        ir_data_d  = ir_data_q;
        ir_ld_d    = 1'b0;
        redirect_d = redirect_q;
        tgt_d      = tgt_q;
`ifdef FETCH_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (branch_valid) begin
                    pc_d = branch_target;
                end else if (fetch_en) begin
                    state_d    = S_FETCH;
                    redirect_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
                    cnt_d      = 8'd0;
`endif
                end
            end
            S_FETCH: begin
                if (mem_ack) begin
                    // A pending (or same-cycle) redirect discards the returned word.
                    if (redirect_q || branch_valid) begin
                        pc_d       = branch_valid ? branch_target : tgt_q;
                        redirect_d = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        ir_data_d = mem_rdata;
                        pc_out_d  = pc_q;
                        pc_d      = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                        ir_ld_d   = 1'b1;
                        state_d   = S_LOAD;
                    end
                end else begin
                    if (branch_valid) begin
                        redirect_d = 1'b1;
                        tgt_d      = branch_target;
                    end
`ifdef FETCH_TIMEOUT_EN
                    if (cnt_q == 8'(TIMEOUT - 1)) begin
                        state_d    = S_IDLE;
                        err_d      = 1'b1;
                        redirect_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
`endif
                end
            end
            S_LOAD: begin
                state_d = S_IDLE;
                if (branch_valid) begin
                    pc_d = branch_target;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            pc_out_q   <= '0;
            ir_data_q  <= '0;
            ir_ld_q    <= 1'b0;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_out_q   <= pc_out_d;
            ir_data_q  <= ir_data_d;
            ir_ld_q    <= ir_ld_d;
            redirect_q <= redirect_d;
        end
    end

    // Redirect target is only consulted while redirect_q is set, so it needs no reset.
    always_ff @(posedge clk) begin
        tgt_q <= tgt_d;
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

    assign mem_req  = (state_q == S_FETCH);
    assign mem_addr = pc_q;
    assign ir_ld    = ir_ld_q;
    assign ir_data  = ir_data_q;
    assign pc_out   = pc_out_q;
    assign busy     = (state_q != S_IDLE);

endmodule
